// File: rtl/cpu_pkg.sv
// Shared CPU definitions: condition codes, flag bit positions and the
// branch-resolver FSM state encoding.
package cpu_pkg;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_V = 1;
   localparam int unsigned FLAG_N = 2;

   typedef enum logic [2:0] {
      COND_AL  = 3'b000,
      COND_EQ  = 3'b001,
      COND_NE  = 3'b010,
      COND_LT  = 3'b011,
      COND_LE  = 3'b100,
      COND_GE  = 3'b101,
      COND_GT  = 3'b110,
      COND_RSV = 3'b111
   } cond_e;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_RESOLVE = 2'd2
   } state_e;

endpackage

// File: rtl/flag_branch_resolver_if.sv
// ALU-flag / branch-request / decision bundle between the datapath and
// control side (master) and the branch resolver (slave).
interface flag_branch_resolver_if;

   logic       flag_load;
   logic       alu_z;
   logic       alu_v;
   logic       alu_n;
   logic       flags_pending;
   logic       br_valid;
   logic [2:0] br_cond;
   logic       br_ready;
   logic       res_valid;
   logic       res_taken;
   logic       res_timeout;
   logic       res_ready;
   logic [2:0] status;

   modport master (
      output flag_load, alu_z, alu_v, alu_n, flags_pending,
      output br_valid, br_cond, res_ready,
      input  br_ready, res_valid, res_taken, res_timeout, status
   );

   modport slave (
      input  flag_load, alu_z, alu_v, alu_n, flags_pending,
      input  br_valid, br_cond, res_ready,
      output br_ready, res_valid, res_taken, res_timeout, status
   );

endinterface

// File: rtl/flag_branch_resolver_cond_eval.sv
// Combinational condition-code evaluator over the {N,V,Z} status register.
module cond_eval
   import cpu_pkg::*;
(
   input  logic [2:0] cond,
   input  logic [2:0] status,
   output logic       taken
);

   logic z;
   logic lt;

   // Decode the condition against the current flags; reserved code never branches
   always_comb begin
      z     = status[FLAG_Z];
      lt    = status[FLAG_N] ^ status[FLAG_V];
      taken = 1'b0;
      case (cond)
         COND_AL: taken = 1'b1;
         COND_EQ: taken = z;
         COND_NE: taken = ~z;
         COND_LT: taken = lt;
         COND_LE: taken = lt | z;
         COND_GE: taken = ~lt;
         COND_GT: taken = ~z & ~lt;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/flag_branch_resolver.sv
// Branch resolver: captures ALU flags into the status register, accepts a
// branch request, waits out any in-flight flag-writing op (bounded by
// WAIT_MAX) and returns a registered taken/not-taken decision.
// Optional macro BRANCH_STATS_EN adds saturating stat_total/stat_taken ports.
module flag_branch_resolver
   import cpu_pkg::*;
#(
   parameter int unsigned WAIT_MAX = 8,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   flag_branch_resolver_if.slave bus
`ifdef BRANCH_STATS_EN
   ,
   output logic [CNT_W-1:0]     stat_total,
   output logic [CNT_W-1:0]     stat_taken
`endif
);

   if (WAIT_MAX < 1 || WAIT_MAX > 255 || CNT_W < 1) begin : g_param_check
      $error("flag_branch_resolver: WAIT_MAX must be 1..255 and CNT_W >= 1");
   end

   state_e     state_q, state_d;
   logic [2:0] status_q, status_d;
   logic [2:0] cond_q, cond_d;
   logic [7:0] wait_q, wait_d;
   logic       tmo_pend_q, tmo_pend_d;
   logic       res_valid_q, res_valid_d;
   logic       res_taken_q, res_taken_d;
   logic       res_timeout_q, res_timeout_d;
   logic       taken;
   logic       accept;

   assign bus.br_ready    = (state_q == ST_IDLE) & reset_n;
   assign bus.res_valid   = res_valid_q;
   assign bus.res_taken   = res_taken_q;
   assign bus.res_timeout = res_timeout_q;
   assign bus.status      = status_q;
   assign accept          = bus.br_valid & bus.br_ready;

   cond_eval u_cond_eval (
      .cond   (cond_q),
      .status (status_q),
      .taken  (taken)
   );

   // Next-state and next-datapath logic.
   // The decision is taken in the first RESOLVE cycle from the status register,
   // so a flag_load on the accept/WAIT-exit edge is already visible to it.
   always_comb begin
      state_d       = state_q;
      status_d      = status_q;
      cond_d        = cond_q;
      wait_d        = wait_q;
      tmo_pend_d    = tmo_pend_q;
      res_valid_d   = res_valid_q;
      res_taken_d   = res_taken_q;
      res_timeout_d = res_timeout_q;

      if (bus.flag_load) begin
         status_d[FLAG_Z] = bus.alu_z;
         status_d[FLAG_V] = bus.alu_v;
         status_d[FLAG_N] = bus.alu_n;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               cond_d     = bus.br_cond;
               wait_d     = '0;
               tmo_pend_d = 1'b0;
               state_d    = bus.flags_pending ? ST_WAIT : ST_RESOLVE;
            end
         end
         ST_WAIT: begin
            wait_d = wait_q + 8'd1;
            if (bus.flag_load || !bus.flags_pending) begin
               state_d = ST_RESOLVE;
            end else if (wait_q == 8'(WAIT_MAX - 1)) begin
               state_d    = ST_RESOLVE;
               tmo_pend_d = 1'b1;
            end
         end
         ST_RESOLVE: begin
            if (!res_valid_q) begin
               res_valid_d   = 1'b1;
               res_taken_d   = taken;
               res_timeout_d = tmo_pend_q;
            end else if (bus.res_ready) begin
               res_valid_d   = 1'b0;
               res_timeout_d = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Status, latched condition, wait counter and decision registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         status_q      <= '0;
         cond_q        <= '0;
         wait_q        <= '0;
         tmo_pend_q    <= 1'b0;
         res_valid_q   <= 1'b0;
         res_taken_q   <= 1'b0;
         res_timeout_q <= 1'b0;
      end else begin
         status_q      <= status_d;
         cond_q        <= cond_d;
         wait_q        <= wait_d;
         tmo_pend_q    <= tmo_pend_d;
         res_valid_q   <= res_valid_d;
         res_taken_q   <= res_taken_d;
         res_timeout_q <= res_timeout_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic hs;
   assign hs = res_valid_q & bus.res_ready;

   // Saturating counters of completed and taken decisions
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stat_total <= '0;
         stat_taken <= '0;
      end else if (hs) begin
         if (stat_total != '1)                stat_total <= stat_total + CNT_W'(1);
         if (res_taken_q && stat_taken != '1) stat_taken <= stat_taken + CNT_W'(1);
      end
   end
`endif

endmodule
